// File: rtl/ascii_number_entry_if.sv
// ascii_number_entry_if
//   Groups the two handshake channels of the number-entry block.
//   Character channel : ascii_in[11:0], ascii_valid (master -> slave),
//                       ascii_ready (slave -> master).
//   Number channel    : num_out[31:0], num_valid (slave -> master),
//                       num_ready (master -> slave).
//   master : keyboard/decoder side plus CPU consumer (testbench side).
//   slave  : the ascii_number_entry block.
interface ascii_number_entry_if;
    logic [11:0] ascii_in;
    logic        ascii_valid;
    logic        ascii_ready;
    logic [31:0] num_out;
    logic        num_valid;
    logic        num_ready;

    modport master (
        output ascii_in,
        output ascii_valid,
        input  ascii_ready,
        input  num_out,
        input  num_valid,
        output num_ready
    );

    modport slave (
        input  ascii_in,
        input  ascii_valid,
        output ascii_ready,
        output num_out,
        output num_valid,
        input  num_ready
    );
endinterface

// File: rtl/ascii_number_entry.sv
// ascii_number_entry
//   Accumulates decimal ASCII digits into a 32-bit value with backspace,
//   escape and enter editing, and hands the committed number to a
//   consumer over a valid/ready handshake.
//
//   Ports:
//     clock        system clock, rising edge
//     resetn       asynchronous active-low reset
//     bus          ascii_number_entry_if.slave (character + number channels)
//     acc_live     running accumulator magnitude (display)
//     digit_count  digits currently entered
//     bad_char     one-cycle pulse, character rejected
//     overflow     one-cycle pulse, digit dropped at MAX_DIGITS
//
//   Build option: define ASCII_NEG_ENTRY_EN to accept a leading '-' and
//   commit the two's-complement negative of the entered magnitude.
module ascii_number_entry #(
    parameter int unsigned MAX_DIGITS = 9,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    ascii_number_entry_if.slave      bus,
    output logic [31:0]              acc_live,
    output logic [CNT_W-1:0]         digit_count,
    output logic                     bad_char,
    output logic                     overflow
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [11:0] KEY_BS    = 12'd8;
    localparam logic [11:0] KEY_ENTER = 12'd13;
    localparam logic [11:0] KEY_ESC   = 12'd27;
    localparam logic [11:0] KEY_0     = 12'd48;
    localparam logic [11:0] KEY_9     = 12'd57;
`ifdef ASCII_NEG_ENTRY_EN
    localparam logic [11:0] KEY_MINUS = 12'd45;
`endif

    state_e             state_q, state_d;
    logic [31:0]        acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [31:0]        num_q,   num_d;
    logic               bad_q,   bad_d;
    logic               ovf_q,   ovf_d;
`ifdef ASCII_NEG_ENTRY_EN
    logic               neg_q,   neg_d;
`endif

    logic               ready;
    logic               take;
    logic               is_digit;
    logic [31:0]        digit_val;

    // Ready is gated by resetn so every output reads 0 while in reset.
    assign ready     = resetn && (state_q != HOLD);
    assign take      = bus.ascii_valid && ready;
    assign is_digit  = (bus.ascii_in >= KEY_0) && (bus.ascii_in <= KEY_9);
    // Codes 48..57 carry the digit value in their low nibble.
    assign digit_val = {28'd0, bus.ascii_in[3:0]};

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            bad_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ASCII_NEG_ENTRY_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            bad_q   <= bad_d;
            ovf_q   <= ovf_d;
`ifdef ASCII_NEG_ENTRY_EN
            neg_q   <= neg_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        bad_d   = 1'b0;
        ovf_d   = 1'b0;
`ifdef ASCII_NEG_ENTRY_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            EMPTY, ENTRY: begin
                if (take) begin
                    if (is_digit) begin
                        if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                            acc_d   = (acc_q * 32'd10) + digit_val;
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = ENTRY;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (bus.ascii_in == KEY_BS) begin
                        if (state_q == ENTRY) begin
                            acc_d = acc_q / 32'd10;
                            cnt_d = cnt_q - CNT_W'(1);
                            if (cnt_q == CNT_W'(1)) begin
                                state_d = EMPTY;
                            end
                        end else begin
`ifdef ASCII_NEG_ENTRY_EN
                            neg_d = 1'b0;
`endif
                        end
                    end else if (bus.ascii_in == KEY_ESC) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = EMPTY;
`ifdef ASCII_NEG_ENTRY_EN
                        neg_d   = 1'b0;
`endif
                    end else if (bus.ascii_in == KEY_ENTER) begin
                        if (state_q == ENTRY) begin
`ifdef ASCII_NEG_ENTRY_EN
                            num_d = neg_q ? (~acc_q + 32'd1) : acc_q;
`else
                            num_d = acc_q;
`endif
                            state_d = HOLD;
                        end else begin
                            bad_d = 1'b1;
                        end
`ifdef ASCII_NEG_ENTRY_EN
                    end else if (bus.ascii_in == KEY_MINUS) begin
                        if ((state_q == EMPTY) && !neg_q) begin
                            neg_d = 1'b1;
                        end else begin
                            bad_d = 1'b1;
                        end
`endif
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // acc_live keeps the committed magnitude until the consumer takes it.
                if (bus.num_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = EMPTY;
`ifdef ASCII_NEG_ENTRY_EN
                    neg_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = EMPTY;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        bus.ascii_ready = ready;
        bus.num_valid   = (state_q == HOLD);
        bus.num_out     = num_q;
        acc_live        = acc_q;
        digit_count     = cnt_q;
        bad_char        = bad_q;
        overflow        = ovf_q;
    end

endmodule

// File: doc/ascii_number_entry.md
Name: ascii_number_entry

Overview:
Downstream of the ASCII digit decoder in the keyboard input path. Consumes a stream of 12-bit ASCII characters through a valid/ready handshake and accumulates decimal digits into a 32-bit value. Supports backspace, escape and enter editing keys. Presents the committed number to the CPU-side register/MMIO consumer through a second valid/ready handshake.

Parameters:
MAX_DIGITS, 9, maximum digits accepted per number; 9 keeps the value below 2^31.
CNT_W, 4, width of digit_count; must hold MAX_DIGITS.

Ports:
clock  input  1  system clock; all state updates on the rising edge
resetn  input  1  asynchronous, active-low reset
ascii_in  input  12  ASCII character code, zero-extended
ascii_valid  input  1  ascii_in is valid this cycle
ascii_ready  output  1  block can accept a character this cycle
num_out  output  32  committed number, two's complement
num_valid  output  1  num_out holds a committed number
num_ready  input  1  consumer accepts num_out
acc_live  output  32  running accumulator, for the 7-segment display
digit_count  output  CNT_W  digits currently entered
bad_char  output  1  one-cycle pulse: character rejected
overflow  output  1  one-cycle pulse: digit dropped because MAX_DIGITS was already reached

Behaviour:
- Reset (resetn low, asynchronous):
  - state = EMPTY.
  - acc_live, num_out, digit_count = 0.
  - num_valid, bad_char, overflow = 0.
  - ascii_ready = 1 once reset is released.
  - Reset mid-entry or mid-HOLD discards everything; a pending num_valid drops immediately.
- States:
  - EMPTY: digit_count = 0.
  - ENTRY: digit_count > 0.
  - HOLD: a result is waiting for the consumer.
- ascii_ready = 1 in EMPTY and ENTRY, 0 in HOLD.
- A character is consumed on an edge where ascii_valid & ascii_ready.
- Its effect is visible on acc_live/digit_count right after that edge (1-cycle latency).
- Digit, codes 48..57 ('0'..'9'):
  - If digit_count < MAX_DIGITS: acc <= acc*10 + (code-48), digit_count++, state = ENTRY.
  - Otherwise: acc unchanged, overflow pulses for 1 cycle.
  - A leading '0' counts as a digit.
- Backspace, code 8:
  - In ENTRY: acc <= acc/10 (unsigned truncating), digit_count--.
  - Goes to EMPTY when digit_count reaches 0.
  - In EMPTY: no effect, no pulse.
- Escape, code 27: acc = 0, digit_count = 0, state = EMPTY.
- Enter, code 13:
  - In ENTRY: num_out <= acc, num_valid <= 1, state = HOLD. acc_live keeps its value until the handshake completes.
  - In EMPTY: ignored, bad_char pulses.
- Any other code (including codes > 127): bad_char pulses for 1 cycle; state unchanged.
- HOLD:
  - num_out and num_valid stay stable until the edge where num_valid & num_ready.
  - On that edge: num_valid <= 0, acc = 0, digit_count = 0, state = EMPTY.
  - ascii_ready = 1 in the following cycle.
  - num_out keeps the last committed value after the handshake.
- num_ready while num_valid = 0: no effect.
- Characters presented while ascii_ready = 0 are not consumed; upstream must hold them.
- bad_char and overflow are never high in the same cycle; at most one character is consumed per cycle.
- Arithmetic is unsigned 32-bit; no wrap is possible while MAX_DIGITS <= 9.

Optional Feature:
ASCII_NEG_ENTRY_EN
- Defined:
  - '-' (code 45) is accepted only in EMPTY with the sign not yet set. It sets an internal neg flag; the state stays EMPTY.
  - Backspace in EMPTY clears neg.
  - Escape clears neg.
  - Enter in ENTRY commits num_out = neg ? -acc : acc (two's complement); neg clears on handshake.
  - Enter with only '-' entered: ignored, bad_char pulses.
  - acc_live always shows the magnitude.
  - A second '-', or '-' in ENTRY: bad_char pulses.
- Undefined:
  - '-' is an ordinary invalid character (bad_char pulse).
  - num_out is always non-negative.

Test Plan:
- Reset, then '1','2','3',Enter, num_ready=1 → acc_live 1,12,123; num_valid rises with num_out=123; one cycle later num_valid=0, digit_count=0, ascii_ready=1.
- '4','5',Backspace,'7',Enter → acc_live 4,45,4,47; num_out=47.
- Ten '9's then Enter → acc_live=999999999 after the 9th digit; overflow pulses once on the 10th; num_out=999999999.
- Enter in EMPTY, and 'A' (65) in ENTRY → bad_char pulses each time; acc_live unchanged.
- '8',Enter with num_ready held 0 for 5 cycles while ascii_valid='3' → ascii_ready=0, num_out=8 stable; after num_ready=1, '3' is consumed the next cycle and acc_live=3.
- With ASCII_NEG_ENTRY_EN: '-','2','5',Enter → num_out=32'hFFFFFFE7 (-25). Without it: '-' gives a bad_char pulse and num_out=25. Also assert resetn low mid-entry: all outputs 0 immediately.
